// File: rtl/mouse_packet_tracker_if.sv
// Byte-stream input and tracked-mouse output bundle for mouse_packet_tracker.
// master = byte source / wrapper side, slave = the tracker itself.
interface mouse_packet_tracker_if;
  logic [7:0] BYTE_IN;
  logic       BYTE_VALID;
  logic       BYTE_ERROR;
  logic [3:0] MOUSE_STATUS;
  logic [7:0] MOUSE_X;
  logic [7:0] MOUSE_Y;
  logic [7:0] MOUSE_MOVE_X;
  logic [7:0] MOUSE_MOVE_Y;
  logic       SEND_INTERRUPT;
  logic [7:0] SYNC_ERR_COUNT;

  modport master (
    output BYTE_IN, BYTE_VALID, BYTE_ERROR,
    input  MOUSE_STATUS, MOUSE_X, MOUSE_Y, MOUSE_MOVE_X, MOUSE_MOVE_Y,
           SEND_INTERRUPT, SYNC_ERR_COUNT
  );

  modport slave (
    input  BYTE_IN, BYTE_VALID, BYTE_ERROR,
    output MOUSE_STATUS, MOUSE_X, MOUSE_Y, MOUSE_MOVE_X, MOUSE_MOVE_Y,
           SEND_INTERRUPT, SYNC_ERR_COUNT
  );
endinterface

// File: rtl/mouse_packet_tracker.sv
// Assembles 3-byte PS/2 mouse packets into a clamped X/Y position plus status and movement.
// Optional macro MOUSE_TRACKER_Y_INVERT_EN: Y -= dy (screen coordinates) instead of Y += dy.
module mouse_packet_tracker #(
  parameter int unsigned MAX_X          = 159,
  parameter int unsigned MAX_Y          = 119,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned TIMEOUT_W      = 21
) (
  input  logic                   CLK_100,
  input  logic                   RESET,
  mouse_packet_tracker_if.slave  bus
);

  localparam logic [1:0] S_B0  = 2'd0;
  localparam logic [1:0] S_B1  = 2'd1;
  localparam logic [1:0] S_B2  = 2'd2;
  localparam logic [1:0] S_UPD = 2'd3;

  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]           X_MAX8  = 8'(MAX_X);
  localparam logic [7:0]           Y_MAX8  = 8'(MAX_Y);

  logic [1:0]           state_q, state_d;
  logic [7:0]           status_q, status_d;
  logic [7:0]           dx_q, dx_d;
  logic [7:0]           dy_q, dy_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [7:0]           x_q, x_d;
  logic [7:0]           y_q, y_d;
  logic [3:0]           mstat_q, mstat_d;
  logic [7:0]           move_x_q, move_x_d;
  logic [7:0]           move_y_q, move_y_d;
  logic                 irq_q, irq_d;
  logic [7:0]           err_q, err_d;

  logic                 err_inc;
  logic signed [9:0]    dx_raw, dy_raw, dx_app, dy_app, sum_x, sum_y;

  function automatic logic [7:0] clamp(input logic signed [9:0] s, input logic [7:0] mx);
    if (s < 10'sd0)                   return 8'd0;
    if (s > $signed({2'b00, mx}))     return mx;
    return s[7:0];
  endfunction

  // |d| saturated to 8 bits; -256 maps to 255
  function automatic logic [7:0] mag(input logic signed [9:0] d);
    logic [9:0] a;
    a = d[9] ? $unsigned(-d) : $unsigned(d);
    return (a > 10'd255) ? 8'hFF : a[7:0];
  endfunction

  // Packet arithmetic, consumed only while in UPD
  always_comb begin
    dx_raw = {status_q[4], status_q[4], dx_q};
    dy_raw = {status_q[5], status_q[5], dy_q};
    dx_app = status_q[6] ? 10'sd0 : dx_raw;
    dy_app = status_q[7] ? 10'sd0 : dy_raw;
    sum_x  = $signed({2'b00, x_q}) + dx_app;
`ifdef MOUSE_TRACKER_Y_INVERT_EN
    sum_y  = $signed({2'b00, y_q}) - dy_app;
`else
    sum_y  = $signed({2'b00, y_q}) + dy_app;
`endif
  end

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    cnt_d    = '0;
    x_d      = x_q;
    y_d      = y_q;
    mstat_d  = mstat_q;
    move_x_d = move_x_q;
    move_y_d = move_y_q;
    irq_d    = 1'b0;
    err_inc  = 1'b0;

    case (state_q)
      S_B0, S_UPD: begin
        if (state_q == S_UPD) begin
          x_d      = clamp(sum_x, X_MAX8);
          y_d      = clamp(sum_y, Y_MAX8);
          move_x_d = status_q[6] ? 8'hFF : mag(dx_raw);
          move_y_d = status_q[7] ? 8'hFF : mag(dy_raw);
          mstat_d  = status_q[3:0];
          irq_d    = 1'b1;
        end
        state_d = S_B0;
        if (bus.BYTE_ERROR) begin
          err_inc = 1'b1;
        end else if (bus.BYTE_VALID) begin
          if (bus.BYTE_IN[3]) begin
            status_d = bus.BYTE_IN;
            state_d  = S_B1;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      default: begin
        // B1 / B2: waiting for a data byte under the inter-byte timeout
        if (bus.BYTE_ERROR) begin
          state_d = S_B0;
          err_inc = 1'b1;
        end else if (bus.BYTE_VALID) begin
          if (state_q == S_B1) begin
            dx_d    = bus.BYTE_IN;
            state_d = S_B2;
          end else begin
            dy_d    = bus.BYTE_IN;
            state_d = S_UPD;
          end
        end else if (cnt_q >= TO_LAST) begin
          state_d = S_B0;
          err_inc = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge CLK_100) begin
    if (RESET) begin
      state_q  <= S_B0;
      status_q <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      cnt_q    <= '0;
      x_q      <= 8'(MAX_X / 2);
      y_q      <= 8'(MAX_Y / 2);
      mstat_q  <= '0;
      move_x_q <= '0;
      move_y_q <= '0;
      irq_q    <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      mstat_q  <= mstat_d;
      move_x_q <= move_x_d;
      move_y_q <= move_y_d;
      irq_q    <= irq_d;
      err_q    <= err_d;
    end
  end

  assign bus.MOUSE_STATUS   = mstat_q;
  assign bus.MOUSE_X        = x_q;
  assign bus.MOUSE_Y        = y_q;
  assign bus.MOUSE_MOVE_X   = move_x_q;
  assign bus.MOUSE_MOVE_Y   = move_y_q;
  assign bus.SEND_INTERRUPT = irq_q;
  assign bus.SYNC_ERR_COUNT = err_q;

endmodule
